// File: rtl/debug_pkg.sv
// Shared state encodings and host command bytes for the debug controller.
package debug_pkg;

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_MODE  = 3'd1,
    ST_DEBUG = 3'd2,
    ST_STEP  = 3'd3,
    ST_DUMP  = 3'd4,
    ST_RUN   = 3'd5,
    ST_FINAL = 3'd6,
    ST_DONE  = 3'd7
  } state_e;

  localparam logic [7:0] CMD_DEBUG  = 8'hFF;
  localparam logic [7:0] CMD_RUN    = 8'h00;
  localparam logic [7:0] CMD_STEP   = 8'hAA;
  localparam logic [7:0] CMD_RUNEND = 8'h55;

endpackage

// File: rtl/debug_tx_serializer.sv
// Streams a loaded snapshot LSB byte first; first byte valid the cycle after load.
// Holds the current byte while tx_ready_i is low; done_o pulses the cycle after the last transfer.
module debug_tx_serializer #(
  parameter int NBYTES = 16
) (
  input  logic                  clock_i,
  input  logic                  reset_ni,
  input  logic                  load_i,
  input  logic [NBYTES*8-1:0]   data_i,
  input  logic                  tx_ready_i,
  output logic                  tx_valid_o,
  output logic [7:0]            tx_byte_o,
  output logic                  done_o
);

  localparam int CW = $clog2(NBYTES + 1);

  logic [NBYTES*8-1:0] buf_q, buf_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;

  always_comb begin
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    if (load_i) begin
      buf_d   = data_i;
      cnt_d   = CW'(NBYTES);
      valid_d = 1'b1;
    end else if (valid_q && tx_ready_i) begin
      // The byte on the wire is always buf_q[7:0]; shifting exposes the next one.
      buf_d = buf_q >> 8;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        valid_d = 1'b0;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      buf_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign tx_valid_o = valid_q;
  assign tx_byte_o  = buf_q[7:0];
  assign done_o     = done_q;

endmodule

// File: rtl/debug_ctrl.sv
// Host debug controller: loads program words, then runs or single-steps the pipeline and dumps status.
// Writes land one cycle after the last rx byte; status bytes obey tx valid/ready, rx is dropped meanwhile.
module debug_ctrl
  import debug_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DUMP_WORDS = 4
) (
  input  logic                             i_clock,
  input  logic                             i_reset_n,
  input  logic                             i_rx_valid,
  input  logic [7:0]                       i_rx_byte,
  output logic                             o_tx_valid,
  output logic [7:0]                       o_tx_byte,
  input  logic                             i_tx_ready,
  input  logic                             i_finish,
  input  logic [DUMP_WORDS*WORD_WIDTH-1:0] i_dump,
  output logic                             o_wr_en,
  output logic [ADDR_WIDTH-1:0]            o_wr_addr,
  output logic [WORD_WIDTH-1:0]            o_wr_data,
  output logic                             o_start,
  output logic                             o_step,
  output logic                             o_error,
  output logic [2:0]                       o_state
);

  localparam int BYTES = WORD_WIDTH / 8;
  localparam int BC_W  = $clog2(BYTES);
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(BYTES - 1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH:0]     addr_q, addr_d;
  logic [BC_W-1:0]         bcnt_q, bcnt_d;
  logic [WORD_WIDTH-9:0]   asm_q, asm_d;
  logic [WORD_WIDTH-1:0]   word_full;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [WORD_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                    error_q, error_d;
  logic                    fin_seen_q, fin_seen_d;
  logic                    start_q, start_d;
  logic                    step_q, step_d;
  logic                    ld_q, ld_d;
  logic                    ser_done;

  // Bytes arrive LSB first, so each new byte enters at the top and slides down.
  assign word_full = {i_rx_byte, asm_q};

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    bcnt_d     = bcnt_q;
    asm_d      = asm_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    error_d    = error_q;
    fin_seen_d = fin_seen_q;
    case (state_q)
      ST_LOAD: begin
        if (i_rx_valid) begin
          asm_d = word_full[WORD_WIDTH-1:8];
          if (bcnt_q == LAST_BYTE) begin
            bcnt_d = '0;
            if (word_full == '0) begin
              state_d = ST_MODE;
            end else if (addr_q[ADDR_WIDTH]) begin
              error_d = 1'b1;
            end else begin
              wr_en_d   = 1'b1;
              wr_addr_d = addr_q[ADDR_WIDTH-1:0];
              wr_data_d = word_full;
              addr_d    = addr_q + 1'b1;
            end
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      ST_MODE: begin
        if (i_rx_valid && i_rx_byte == CMD_DEBUG) state_d = ST_DEBUG;
        else if (i_rx_valid && i_rx_byte == CMD_RUN) state_d = ST_RUN;
      end
      ST_DEBUG: begin
        if (i_finish) state_d = ST_DONE;
        else if (i_rx_valid && i_rx_byte == CMD_STEP) state_d = ST_STEP;
        else if (i_rx_valid && i_rx_byte == CMD_RUNEND) state_d = ST_RUN;
      end
      ST_STEP: begin
        if (i_finish) fin_seen_d = 1'b1;
        state_d = ST_DUMP;
      end
      ST_DUMP: begin
        if (i_finish) fin_seen_d = 1'b1;
        if (ser_done) state_d = (fin_seen_q || i_finish) ? ST_DONE : ST_DEBUG;
      end
      ST_RUN: begin
        if (i_finish) state_d = ST_FINAL;
      end
      ST_FINAL: begin
        if (ser_done) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_LOAD;
    endcase
  end

  // Snapshot is taken during the first dump cycle, i.e. one cycle after the step pulse.
  assign ld_d    = (state_d == ST_DUMP  && state_q != ST_DUMP) ||
                   (state_d == ST_FINAL && state_q != ST_FINAL);
  assign start_d = state_d inside {ST_DEBUG, ST_STEP, ST_DUMP, ST_RUN, ST_FINAL};
  assign step_d  = state_d inside {ST_STEP, ST_RUN};

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ST_LOAD;
      addr_q     <= '0;
      bcnt_q     <= '0;
      asm_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      error_q    <= 1'b0;
      fin_seen_q <= 1'b0;
      start_q    <= 1'b0;
      step_q     <= 1'b0;
      ld_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      bcnt_q     <= bcnt_d;
      asm_q      <= asm_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      error_q    <= error_d;
      fin_seen_q <= fin_seen_d;
      start_q    <= start_d;
      step_q     <= step_d;
      ld_q       <= ld_d;
    end
  end

  debug_tx_serializer #(
    .NBYTES(DUMP_WORDS * BYTES)
  ) u_ser (
    .clock_i   (i_clock),
    .reset_ni  (i_reset_n),
    .load_i    (ld_q),
    .data_i    (i_dump),
    .tx_ready_i(i_tx_ready),
    .tx_valid_o(o_tx_valid),
    .tx_byte_o (o_tx_byte),
    .done_o    (ser_done)
  );

  assign o_wr_en   = wr_en_q;
  assign o_wr_addr = wr_addr_q;
  assign o_wr_data = wr_data_q;
  assign o_start   = start_q;
  assign o_step    = step_q;
  assign o_error   = error_q;
  assign o_state   = state_q;

endmodule

// File: tb/tb_debug_ctrl.sv
// Directed bench for debug_ctrl with 32-bit words, 4-entry memory and two status words.
module tb_debug_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        tx_valid;
  logic [7:0]  tx_byte;
  logic        tx_ready;
  logic        finish;
  logic [63:0] dump;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [31:0] wr_data;
  logic        start;
  logic        step;
  logic        err;
  logic [2:0]  state;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_bytes [8];

  always #5 clk = ~clk;

  debug_ctrl #(.WORD_WIDTH(32), .ADDR_WIDTH(2), .DUMP_WORDS(2)) dut (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_rx_valid(rx_valid), .i_rx_byte(rx_byte),
    .o_tx_valid(tx_valid), .o_tx_byte(tx_byte), .i_tx_ready(tx_ready),
    .i_finish(finish), .i_dump(dump),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_start(start), .o_step(step), .o_error(err), .o_state(state)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    tick();
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) send_byte(w[b*8 +: 8]);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s);
    for (int i = 0; i < 50 && state !== s; i++) tick();
    chk(tag, state, s);
  endtask

  // Collects 8 bytes; when toggle is set, ready alternates so each byte is held once.
  task automatic collect(input string tag, input bit toggle);
    int   got = 0;
    bit   pend = 0;
    logic [7:0] held = 0;
    for (int i = 0; i < 100 && got < 8; i++) begin
      if (pend) chk({tag, "_hold"}, tx_byte, held);
      tx_ready = toggle ? i[0] : 1'b1;
      if (tx_valid && tx_ready) begin
        chk(tag, tx_byte, exp_bytes[got]);
        got++;
      end
      pend = tx_valid && !tx_ready;
      held = tx_byte;
      tick();
    end
    tx_ready = 1'b0;
    chk({tag, "_count"}, got, 8);
  endtask

  initial begin
    rst_n = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
    tx_ready = 1'b0; finish = 1'b0; dump = 64'h0;
    tick(); tick();
    chk("rst_state", state, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_byte", tx_byte, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_start", start, 0);
    chk("rst_step", step, 0);
    chk("rst_error", err, 0);
    rst_n = 1'b1;

    // Program load and terminator
    send_word(32'h2001000A);
    chk("w0_en", wr_en, 1);
    chk("w0_addr", wr_addr, 0);
    chk("w0_data", wr_data, 32'h2001000A);
    tick();
    chk("w0_pulse_len", wr_en, 0);
    send_word(32'h00000001);
    chk("w1_en", wr_en, 1);
    chk("w1_addr", wr_addr, 1);
    chk("w1_data", wr_data, 32'h00000001);
    send_word(32'h0);
    chk("term_no_wr", wr_en, 0);
    chk("term_state", state, 1);

    // Mode selection
    send_byte(8'h37);
    chk("mode_ignore", state, 1);
    send_byte(8'hFF);
    chk("debug_state", state, 2);
    chk("debug_start", start, 1);
    chk("debug_step", step, 0);

    // Single step and dump with ready toggling
    dump = {32'h00000011, 32'h00000004};
    send_byte(8'hAA);
    chk("step_state", state, 3);
    chk("step_pulse", step, 1);
    tick();
    chk("dump_state", state, 4);
    chk("step_len", step, 0);
    chk("dump_valid_late", tx_valid, 0);
    tick();
    chk("dump_valid_rise", tx_valid, 1);
    dump = 64'hDEADBEEF_DEADBEEF;
    exp_bytes = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h11, 8'h00, 8'h00, 8'h00};
    collect("dump_byte", 1'b1);
    wait_state("dump_return", 3'd2);
    chk("dump_ret_valid", tx_valid, 0);
    chk("dump_ret_start", start, 1);

    // Load overflow with a 4-entry memory
    do_reset();
    for (int w = 1; w <= 5; w++) begin
      send_word(32'(w));
      chk("ovf_wr_en", wr_en, (w <= 4) ? 1 : 0);
      chk("ovf_error", err, (w == 5) ? 1 : 0);
    end
    chk("ovf_last_addr", wr_addr, 3);
    send_word(32'h0);
    chk("ovf_term_state", state, 1);
    chk("ovf_sticky", err, 1);

    // Run to end and final dump
    send_byte(8'h00);
    chk("run_state", state, 5);
    chk("run_start", start, 1);
    chk("run_step", step, 1);
    dump = {32'hCAFEBABE, 32'h12345678};
    finish = 1'b1;
    tick();
    finish = 1'b0;
    chk("final_state", state, 6);
    chk("final_step", step, 0);
    exp_bytes = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hBE, 8'hBA, 8'hFE, 8'hCA};
    collect("final_byte", 1'b0);
    wait_state("done_state", 3'd7);
    chk("done_start", start, 0);
    chk("done_step", step, 0);
    send_byte(8'hFF);
    chk("done_sticky", state, 7);

    // Reset in the middle of a dump
    do_reset();
    send_word(32'h0);
    send_byte(8'hFF);
    dump = 64'h1;
    send_byte(8'hAA);
    for (int i = 0; i < 10 && !tx_valid; i++) tick();
    chk("mid_valid", tx_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", tx_valid, 0);
    chk("mid_rst_state", state, 0);
    chk("mid_rst_start", start, 0);
    chk("mid_rst_byte", tx_byte, 0);
    tick();
    rst_n = 1'b1;
    send_word(32'h0000BEEF);
    chk("reload_en", wr_en, 1);
    chk("reload_addr", wr_addr, 0);
    chk("reload_data", wr_data, 32'h0000BEEF);

    // Finish beats a command in the same DEBUG cycle
    do_reset();
    send_word(32'h0);
    send_byte(8'hFF);
    tick();
    rx_valid = 1'b1; rx_byte = 8'hAA; finish = 1'b1;
    tick();
    rx_valid = 1'b0; finish = 1'b0;
    chk("finish_wins", state, 7);
    chk("finish_start", start, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
